// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two ports (fixed priority, or round-robin when MEM_ARB_RR_EN is defined) and runs SETUP/STROBE/ACK on a level-strobed RAM.
// Latency: req sampled -> ack after STROBE_CYC+1 more edges; backpressure: the loser keeps req high and is served later, nothing is queued.
module mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy
);

  localparam int SC    = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
  localparam int CNT_W = (SC > 1) ? $clog2(SC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              busy_q, busy_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              win;
  logic              grant;
  logic              leave_strobe;

  // win is only meaningful when at least one port requests
  always_comb begin
    win = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (p0_req && p1_req) win = ~last_grant_q;
    else                  win = p1_req;
`else
    win = ~p0_req;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (p0_req || p1_req) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant        = (state_q == IDLE) && (state_d == SETUP);
  assign leave_strobe = (state_q == STROBE) && (state_d == ACK);

  always_comb begin
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    wr_d          = wr_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    cnt_d         = cnt_q;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    if (grant) begin
      gnt_d         = win;
      last_grant_d  = win;
      wr_d          = win ? p1_wr    : p0_wr;
      mem_address_d = win ? p1_addr  : p0_addr;
      mem_data_in_d = win ? p1_wdata : p0_wdata;
    end
    if (state_q == SETUP)                      cnt_d = CNT_LOAD;
    else if (state_q == STROBE && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    // RAM clears data_out as soon as read falls, so sample on the falling edge of the strobe
    if (leave_strobe && !wr_q) begin
      if (gnt_q) p1_rdata_d = mem_data_out;
      else       p0_rdata_d = mem_data_out;
    end
    mem_read_d  = (state_d == STROBE) && !wr_q;
    mem_write_d = (state_d == STROBE) &&  wr_q;
    busy_d      = (state_d != IDLE);
    p0_ack_d    = leave_strobe && !gnt_q;
    p1_ack_d    = leave_strobe &&  gnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      gnt_q         <= 1'b0;
      wr_q          <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      gnt_q         <= gnt_d;
      wr_q          <= wr_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      busy_q        <= busy_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign busy        = busy_q;
  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;

endmodule
